// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - LDM/STM block-transfer sequencer; base writeback under LDM_STM_BASE_WB_EN
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre_index,
    input  logic              up,
    input  logic              wb_en,
    input  logic [3:0]        base_reg,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       reg_list,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        rd_reg_num,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              reg_write,
    output logic [3:0]        write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef LDM_STM_BASE_WB_EN
    localparam logic [2:0] S_WB    = 3'd3;
`endif
    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [2:0]        state_q, state_d;
    logic [15:0]       list_q, list_d;
    logic              is_load_q, is_load_d;
    logic              pre_q, pre_d;
    logic              up_q, up_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef LDM_STM_BASE_WB_EN
    logic              wb_q, wb_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic [ADDR_W-1:0] final_base_q, final_base_d;
`else
    logic              unused_wb_inputs;
    assign unused_wb_inputs = wb_en ^ (|base_reg);
`endif

    logic [4:0]        n;
    logic [3:0]        cur;
    logic [ADDR_W-1:0] n4;

    always_comb begin
        n   = '0;
        cur = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(list_q[i]);
        for (int i = 15; i >= 0; i--) if (list_q[i]) cur = 4'(i);
    end

    assign n4   = ADDR_W'({n, 2'b00});
    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        list_d     = list_q;
        is_load_d  = is_load_q;
        pre_d      = pre_q;
        up_d       = up_q;
        addr_d     = addr_q;
`ifdef LDM_STM_BASE_WB_EN
        wb_d         = wb_q;
        base_reg_d   = base_reg_q;
        final_base_d = final_base_q;
`endif
        rd_reg_num = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SETUP;
                    list_d    = reg_list;
                    is_load_d = is_load;
                    pre_d     = pre_index;
                    up_d      = up;
                    addr_d    = base_addr;
`ifdef LDM_STM_BASE_WB_EN
                    // An LDM that reloads its own base keeps the loaded value.
                    wb_d       = wb_en && !(is_load && reg_list[base_reg]);
                    base_reg_d = base_reg;
`endif
                end
            end
            S_SETUP: begin
                case ({pre_q, up_q})
                    2'b01:   addr_d = addr_q;
                    2'b11:   addr_d = addr_q + FOUR;
                    2'b00:   addr_d = addr_q - n4 + FOUR;
                    default: addr_d = addr_q - n4;
                endcase
`ifdef LDM_STM_BASE_WB_EN
                final_base_d = up_q ? (addr_q + n4) : (addr_q - n4);
`endif
                state_d = (n == 5'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                rd_reg_num = cur;
                mem_req    = 1'b1;
                mem_we     = ~is_load_q;
                mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata  = is_load_q ? '0 : store_data;
                if (mem_ready) begin
                    if (is_load_q) begin
                        reg_write  = 1'b1;
                        write_reg  = cur;
                        write_data = mem_rdata;
                    end
                    list_d = list_q & ~(16'd1 << cur);
                    addr_d = addr_q + FOUR;
                    if (list_d == 16'd0) begin
`ifdef LDM_STM_BASE_WB_EN
                        state_d = wb_q ? S_WB : S_DONE;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef LDM_STM_BASE_WB_EN
            S_WB: begin
                reg_write  = 1'b1;
                write_reg  = base_reg_q;
                write_data = DATA_W'(final_base_q);
                state_d    = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            list_q    <= '0;
            is_load_q <= 1'b0;
            pre_q     <= 1'b0;
            up_q      <= 1'b0;
            addr_q    <= '0;
`ifdef LDM_STM_BASE_WB_EN
            wb_q         <= 1'b0;
            base_reg_q   <= '0;
            final_base_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            list_q    <= list_d;
            is_load_q <= is_load_d;
            pre_q     <= pre_d;
            up_q      <= up_d;
            addr_q    <= addr_d;
`ifdef LDM_STM_BASE_WB_EN
            wb_q         <= wb_d;
            base_reg_q   <= base_reg_d;
            final_base_q <= final_base_d;
`endif
        end
    end

endmodule
